siw_memory_bram_arb: RTL

//  Two-requester arbiter sharing port A of one siw_memory_bram_<n> instance (1024x32, 2-cycle registered read).

---
 rtl/siw_memory_bram_arb.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/siw_memory_bram_arb.sv
// siw_memory_bram_arb
//   Two-requester arbiter in front of port A of a 1024x32 BRAM with a
//   2-cycle registered read. One access is granted per cycle. The granted
//   command is registered toward the BRAM, and a {valid,id} shift register
//   tracks reads in flight so that returning data is steered to its owner.
//
//   Optional build macro: SIW_MEMORY_BRAM_ARB_PRIO_EN
//     defined     : requester 0 has fixed priority (requester 1 may starve)
//     not defined : round-robin between the two requesters
//
//   Read timeline (RD_LAT = 2):
//     T    req & gnt, command captured
//     T+1  command presented at the BRAM
//     T+3  BRAM output valid, rvalid_<id> = 1

module siw_memory_bram_arb #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          siw_memory_bram_arb_clk,
    input  logic          siw_memory_bram_arb_reset,
    input  logic          siw_memory_bram_arb_init,

    input  logic          siw_memory_bram_arb_req_0,
    input  logic          siw_memory_bram_arb_we_0,
    input  logic [AW-1:0] siw_memory_bram_arb_addr_0,
    input  logic [DW-1:0] siw_memory_bram_arb_wdata_0,
    input  logic          siw_memory_bram_arb_req_1,
    input  logic          siw_memory_bram_arb_we_1,
    input  logic [AW-1:0] siw_memory_bram_arb_addr_1,
    input  logic [DW-1:0] siw_memory_bram_arb_wdata_1,

    output logic          siw_memory_bram_arb_gnt_0,
    output logic          siw_memory_bram_arb_gnt_1,
    output logic          siw_memory_bram_arb_rvalid_0,
    output logic          siw_memory_bram_arb_rvalid_1,
    output logic [DW-1:0] siw_memory_bram_arb_rdata,
    output logic          siw_memory_bram_arb_busy,

    output logic          siw_memory_bram_arb_mem_enable,
    output logic          siw_memory_bram_arb_mem_we,
    output logic [AW-1:0] siw_memory_bram_arb_mem_addr,
    output logic [DW-1:0] siw_memory_bram_arb_mem_wdata,
    output logic [1:0]    siw_memory_bram_arb_mem_conf,
    input  logic [DW-1:0] siw_memory_bram_arb_mem_rdata
);

    // Short local aliases for the clock and the control inputs
    logic clk, rst, init;
    assign clk  = siw_memory_bram_arb_clk;
    assign rst  = siw_memory_bram_arb_reset;
    assign init = siw_memory_bram_arb_init;

    // Grant decision and the selected requester's command
    logic          gnt0, gnt1, accept;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Registered BRAM command
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    // Read-tracking shift register: stage 0 is the command stage, and the
    // last stage lines up with the BRAM output
    logic [RD_LAT:0] vld_q, vld_d;
    logic [RD_LAT:0] id_q, id_d;

`ifdef SIW_MEMORY_BRAM_ARB_PRIO_EN
    // Fixed priority: requester 0 always wins; grants are blocked in reset and init
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !init) begin
            gnt0 = siw_memory_bram_arb_req_0;
            gnt1 = siw_memory_bram_arb_req_1 & ~siw_memory_bram_arb_req_0;
        end
    end
`else
    // Round-robin pointer: id of the requester favoured on the next conflict
    logic rr_q, rr_d;

    // Round-robin grant: a lone request wins, and a conflict goes to rr_q
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !init) begin
            if (siw_memory_bram_arb_req_0 && siw_memory_bram_arb_req_1) begin
                gnt0 = ~rr_q;
                gnt1 = rr_q;
            end else begin
                gnt0 = siw_memory_bram_arb_req_0;
                gnt1 = siw_memory_bram_arb_req_1;
            end
        end
    end

    // Pointer next state: favour the other requester after an accept; init returns it to 0
    always_comb begin
        rr_d = rr_q;
        if (init)
            rr_d = 1'b0;
        else if (accept)
            rr_d = ~gnt1;
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_q <= 1'b0;
        else
            rr_q <= rr_d;
    end
`endif

    // Grant implies request, so any grant is an accepted access
    assign accept = gnt0 | gnt1;

    // Mux the winner's command toward the command stage
    always_comb begin
        sel_we    = siw_memory_bram_arb_we_0;
        sel_addr  = siw_memory_bram_arb_addr_0;
        sel_wdata = siw_memory_bram_arb_wdata_0;
        if (gnt1) begin
            sel_we    = siw_memory_bram_arb_we_1;
            sel_addr  = siw_memory_bram_arb_addr_1;
            sel_wdata = siw_memory_bram_arb_wdata_1;
        end
    end

    // Command stage next state: strobes fall when idle, address and data hold
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (!init && accept) begin
            mem_en_d    = 1'b1;
            mem_we_d    = sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
        end
    end

    // Command stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tracker next state: only accepted reads enter, and init drops everything in flight
    always_comb begin
        vld_d = {vld_q[RD_LAT-1:0], accept & ~sel_we};
        id_d  = {id_q[RD_LAT-1:0], gnt1};
        if (init)
            vld_d = '0;
    end

    // Tracker registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign siw_memory_bram_arb_gnt_0      = gnt0;
    assign siw_memory_bram_arb_gnt_1      = gnt1;
    assign siw_memory_bram_arb_rvalid_0   = vld_q[RD_LAT] & ~id_q[RD_LAT];
    assign siw_memory_bram_arb_rvalid_1   = vld_q[RD_LAT] &  id_q[RD_LAT];
    assign siw_memory_bram_arb_rdata      = siw_memory_bram_arb_mem_rdata;
    assign siw_memory_bram_arb_busy       = |vld_q;
    assign siw_memory_bram_arb_mem_enable = mem_en_q;
    assign siw_memory_bram_arb_mem_we     = mem_we_q;
    assign siw_memory_bram_arb_mem_addr   = mem_addr_q;
    assign siw_memory_bram_arb_mem_wdata  = mem_wdata_q;
    assign siw_memory_bram_arb_mem_conf   = 2'd0;

endmodule
